// File: rtl/ibus_dbus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// ibus_dbus_arbiter_pkg
//   Shared types for the fetch/memory-stage arbiter slice: request/response
//   bus structs, arbiter state and owner encodings, and the constants used
//   to widen an ibus fetch into a downstream (dbus-shaped) request.
// ---------------------------------------------------------------------------
package ibus_dbus_arbiter_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;
  typedef logic [3:0]  strobe_t;

  typedef enum logic [2:0] {
    MSIZE1 = 3'b000,
    MSIZE2 = 3'b001,
    MSIZE4 = 3'b010
  } msize_t;

  typedef struct packed {
    logic  valid;
    addr_t addr;
  } ibus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } ibus_resp_t;

  typedef struct packed {
    logic    valid;
    addr_t   addr;
    msize_t  size;
    strobe_t strobe;
    word_t   data;
  } dbus_req_t;

  typedef struct packed {
    logic  addr_ok;
    logic  data_ok;
    word_t data;
  } dbus_resp_t;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } arb_owner_t;

  // A fetch is always a full-word read: no byte enables, no write data.
  localparam msize_t  IBUS_MSIZE  = MSIZE4;
  localparam strobe_t IBUS_STROBE = 4'b0000;
  localparam word_t   IBUS_WDATA  = 32'h0000_0000;

  // Widen a fetch request into the downstream request shape.
  function automatic dbus_req_t ibus_to_dbus(input ibus_req_t req);
    dbus_req_t m;
    m.valid  = req.valid;
    m.addr   = req.addr;
    m.size   = IBUS_MSIZE;
    m.strobe = IBUS_STROBE;
    m.data   = IBUS_WDATA;
    return m;
  endfunction

  // The requester on the other side of the arbiter.
  function automatic arb_owner_t other_side(input arb_owner_t side);
    arb_owner_t o;
    if (side == OWN_D) begin
      o = OWN_I;
    end else begin
      o = OWN_D;
    end
    return o;
  endfunction

endpackage

// File: rtl/ibus_dbus_arbiter_arb_pick.sv
// ---------------------------------------------------------------------------
// arb_pick
//   Purely combinational two-way winner selection, kept separate so a later
//   uncached/cached port split can reuse it.
//   Ports:
//     i_valid     in   fetch side is requesting
//     d_valid     in   memory-stage side is requesting
//     last_winner in   side that completed most recently (round robin only)
//     winner      out  chosen side (meaningful only when any=1)
//     any         out  at least one side is requesting
// ---------------------------------------------------------------------------
module arb_pick
  import ibus_dbus_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b0,
  parameter bit DBUS_FIRST  = 1'b1
) (
  input  logic       i_valid,
  input  logic       d_valid,
  input  arb_owner_t last_winner,
  output arb_owner_t winner,
  output logic       any
);

  localparam arb_owner_t FIXED_WINNER = DBUS_FIRST ? OWN_D : OWN_I;

  // Resolve a single requester directly; only a tie consults the policy.
  always_comb begin
    winner = FIXED_WINNER;
    any    = i_valid | d_valid;
    case ({i_valid, d_valid})
      2'b11: begin
        if (ROUND_ROBIN) begin
          winner = other_side(last_winner);
        end else begin
          winner = FIXED_WINNER;
        end
      end
      2'b10:   winner = OWN_I;
      2'b01:   winner = OWN_D;
      2'b00:   winner = FIXED_WINNER;
      default: winner = FIXED_WINNER;
    endcase
  end

endmodule

// File: rtl/ibus_dbus_arbiter_chk.sv
// ---------------------------------------------------------------------------
// ibus_dbus_arbiter_chk
//   Protocol invariants of the arbiter, kept apart from the datapath.
//   Ports:
//     clk, reset   clock and synchronous active-high reset
//     state        arbiter state register
//     i_data_ok    completion forwarded to the fetch side
//     d_data_ok    completion forwarded to the memory-stage side
//     m_valid      downstream request valid
//     m_addr_ok    downstream address accept
//     m_data_ok    downstream completion
// ---------------------------------------------------------------------------
module ibus_dbus_arbiter_chk
  import ibus_dbus_arbiter_pkg::*;
(
  input logic       clk,
  input logic       reset,
  input arb_state_t state,
  input logic       i_data_ok,
  input logic       d_data_ok,
  input logic       m_valid,
  input logic       m_addr_ok,
  input logic       m_data_ok
);

  // Only one requester may see a completion in any cycle.
  a_one_data_ok: assert property (@(posedge clk) disable iff (reset)
    !(i_data_ok && d_data_ok));

  // No new request leaves while the single outstanding one is in flight.
  a_no_req_in_data: assert property (@(posedge clk) disable iff (reset)
    (state == ARB_DATA) |-> !m_valid);

  // A completion only arrives for an accepted address.
  a_data_ok_legal: assert property (@(posedge clk) disable iff (reset)
    m_data_ok |-> ((state == ARB_DATA) || m_addr_ok));

endmodule

// File: rtl/ibus_dbus_arbiter.sv
// ---------------------------------------------------------------------------
// ibus_dbus_arbiter
//   Shares one downstream memory port between the fetch bus (ibus) and the
//   memory-stage bus (dbus). One transaction outstanding at a time; the
//   owner is locked from grant until its data_ok. Grant in ARB_IDLE is
//   combinational, so a request reaches mreq in the cycle it is raised.
//   Ports:
//     clk    in   clock
//     reset  in   synchronous, active-high reset
//     ireq   in   fetch request {valid, addr}
//     iresp  out  fetch response {addr_ok, data_ok, data}
//     dreq   in   memory-stage request {valid, addr, size, strobe, data}
//     dresp  out  memory-stage response {addr_ok, data_ok, data}
//     mreq   out  downstream request
//     mresp  in   downstream response
// ---------------------------------------------------------------------------
module ibus_dbus_arbiter
  import ibus_dbus_arbiter_pkg::*;
#(
  parameter bit ROUND_ROBIN = 1'b0,
  parameter bit DBUS_FIRST  = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  ibus_req_t  ireq,
  output ibus_resp_t iresp,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp,
  output dbus_req_t  mreq,
  input  dbus_resp_t mresp
);

  // last_winner starts on the non-favoured side so the favoured side takes
  // the first round-robin tie.
  localparam arb_owner_t RESET_LAST_WINNER = DBUS_FIRST ? OWN_I : OWN_D;

  arb_state_t state_r;
  arb_state_t next_state_s;
  arb_owner_t owner_r;
  arb_owner_t next_owner_s;
  arb_owner_t last_winner_r;
  arb_owner_t next_last_winner_s;

  arb_owner_t winner_s;
  arb_owner_t sel_owner_s;
  logic       any_s;
  logic       sel_valid_s;
  logic       fwd_addr_ok_s;
  logic       fwd_data_ok_s;
  dbus_req_t  ibus_as_dbus_s;

  arb_pick #(
    .ROUND_ROBIN (ROUND_ROBIN),
    .DBUS_FIRST  (DBUS_FIRST)
  ) u_pick (
    .i_valid     (ireq.valid),
    .d_valid     (dreq.valid),
    .last_winner (last_winner_r),
    .winner      (winner_s),
    .any         (any_s)
  );

  // Side currently steering the downstream port and its live valid.
  always_comb begin
    ibus_as_dbus_s = ibus_to_dbus(ireq);
    if (state_r == ARB_IDLE) begin
      sel_owner_s = winner_s;
    end else begin
      sel_owner_s = owner_r;
    end
    if (sel_owner_s == OWN_D) begin
      sel_valid_s = dreq.valid;
    end else begin
      sel_valid_s = ireq.valid;
    end
  end

  // Handshake qualified for the selected side; addr_ok is meaningless once
  // the address has been accepted.
  always_comb begin
    fwd_addr_ok_s = 1'b0;
    fwd_data_ok_s = 1'b0;
    case (state_r)
      ARB_IDLE, ARB_ADDR: begin
        fwd_addr_ok_s = sel_valid_s & mresp.addr_ok;
        fwd_data_ok_s = sel_valid_s & mresp.data_ok;
      end
      ARB_DATA: begin
        fwd_addr_ok_s = 1'b0;
        fwd_data_ok_s = mresp.data_ok;
      end
      default: begin
        fwd_addr_ok_s = 1'b0;
        fwd_data_ok_s = 1'b0;
      end
    endcase
  end

  // Downstream request and upstream responses; all quiet while in reset.
  always_comb begin
    mreq  = '0;
    iresp = '0;
    dresp = '0;
    if (!reset) begin
      if (sel_owner_s == OWN_D) begin
        mreq = dreq;
      end else begin
        mreq = ibus_as_dbus_s;
      end
      // Requesters keep valid high through the data wait; do not reissue.
      if (state_r == ARB_DATA) begin
        mreq.valid = 1'b0;
      end else begin
        mreq.valid = sel_valid_s;
      end
      iresp.data = mresp.data;
      dresp.data = mresp.data;
      if (sel_owner_s == OWN_D) begin
        dresp.addr_ok = fwd_addr_ok_s;
        dresp.data_ok = fwd_data_ok_s;
      end else begin
        iresp.addr_ok = fwd_addr_ok_s;
        iresp.data_ok = fwd_data_ok_s;
      end
    end else begin
      mreq  = '0;
      iresp = '0;
      dresp = '0;
    end
  end

  // Next-state, ownership lock and round-robin history.
  always_comb begin
    next_state_s       = state_r;
    next_owner_s       = owner_r;
    next_last_winner_s = last_winner_r;
    case (state_r)
      ARB_IDLE: begin
        if (any_s && fwd_addr_ok_s && fwd_data_ok_s) begin
          next_state_s       = ARB_IDLE;
          next_last_winner_s = winner_s;
        end else if (any_s && fwd_addr_ok_s) begin
          next_state_s = ARB_DATA;
          next_owner_s = winner_s;
        end else if (any_s) begin
          next_state_s = ARB_ADDR;
          next_owner_s = winner_s;
        end else begin
          next_state_s = ARB_IDLE;
        end
      end
      ARB_ADDR: begin
        // A withdrawn request never reached the downstream: just release.
        if (!sel_valid_s) begin
          next_state_s = ARB_IDLE;
        end else if (fwd_addr_ok_s && fwd_data_ok_s) begin
          next_state_s       = ARB_IDLE;
          next_last_winner_s = owner_r;
        end else if (fwd_addr_ok_s) begin
          next_state_s = ARB_DATA;
        end else begin
          next_state_s = ARB_ADDR;
        end
      end
      ARB_DATA: begin
        if (fwd_data_ok_s) begin
          next_state_s       = ARB_IDLE;
          next_last_winner_s = owner_r;
        end else begin
          next_state_s = ARB_DATA;
        end
      end
      default: begin
        next_state_s = ARB_IDLE;
      end
    endcase
  end

  // State registers; reset drops any ownership along with the downstream.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r       <= ARB_IDLE;
      owner_r       <= OWN_D;
      last_winner_r <= RESET_LAST_WINNER;
    end else begin
      state_r       <= next_state_s;
      owner_r       <= next_owner_s;
      last_winner_r <= next_last_winner_s;
    end
  end

  ibus_dbus_arbiter_chk u_chk (
    .clk       (clk),
    .reset     (reset),
    .state     (state_r),
    .i_data_ok (iresp.data_ok),
    .d_data_ok (dresp.data_ok),
    .m_valid   (mreq.valid),
    .m_addr_ok (mresp.addr_ok),
    .m_data_ok (mresp.data_ok)
  );

endmodule

// File: tb/tb_ibus_dbus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ibus_dbus_arbiter
//   Directed scenarios followed by randomized traffic, every cycle compared
//   against a grant-lock reference model of the arbiter.
// ---------------------------------------------------------------------------
module tb_ibus_dbus_arbiter;
  import ibus_dbus_arbiter_pkg::*;

  localparam bit RR = 1'b1;
  localparam bit DF = 1'b1;

  localparam int G_NONE = 0;  // nobody holds the port
  localparam int G_HELD = 1;  // granted, address not yet accepted
  localparam int G_WAIT = 2;  // address accepted, waiting for data

  logic       clk;
  logic       reset;
  ibus_req_t  ireq;
  ibus_resp_t iresp;
  dbus_req_t  dreq;
  dbus_resp_t dresp;
  dbus_req_t  mreq;
  dbus_resp_t mresp;

  int checks = 0;
  int errors = 0;

  // reference model state
  int phase  = G_NONE;
  bit hold_d = 1'b0;
  bit fav_d  = DF;
  bit cur_d, cur_gv, cur_aok, cur_dok;
  bit done_i = 1'b0;
  bit done_d = 1'b0;
  int handshakes = 0;
  bit obs_winners[$];

  ibus_dbus_arbiter #(.ROUND_ROBIN(RR), .DBUS_FIRST(DF)) dut (
    .clk   (clk),
    .reset (reset),
    .ireq  (ireq),
    .iresp (iresp),
    .dreq  (dreq),
    .dresp (dresp),
    .mreq  (mreq),
    .mresp (mresp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_i(input bit v, input logic [31:0] a);
    ireq.valid = v;
    ireq.addr  = a;
  endtask

  task automatic set_d(input bit v, input logic [31:0] a, input msize_t s,
                       input logic [3:0] st, input logic [31:0] dt);
    dreq.valid  = v;
    dreq.addr   = a;
    dreq.size   = s;
    dreq.strobe = st;
    dreq.data   = dt;
  endtask

  task automatic set_m(input bit aok, input bit dok, input logic [31:0] dt);
    mresp.addr_ok = aok;
    mresp.data_ok = dok;
    mresp.data    = dt;
  endtask

  // Who owns the port this cycle and whether that side is asking.
  task automatic predict();
    if (phase != G_NONE) cur_d = hold_d;
    else if (ireq.valid && dreq.valid) cur_d = RR ? fav_d : DF;
    else cur_d = dreq.valid;
    cur_gv = cur_d ? dreq.valid : ireq.valid;
  endtask

  // Compare all outputs against the model, mid-cycle.
  task automatic step();
    dbus_req_t  em;
    ibus_resp_t ei;
    dbus_resp_t ed;
    #3;
    predict();
    cur_aok = !reset && (phase != G_WAIT) && cur_gv && mresp.addr_ok;
    cur_dok = !reset && ((phase == G_WAIT) ? mresp.data_ok : (cur_gv && mresp.data_ok));
    em = '0;
    ei = '0;
    ed = '0;
    if (!reset) begin
      if (cur_d) begin
        em = dreq;
      end else begin
        em.valid  = ireq.valid;
        em.addr   = ireq.addr;
        em.size   = MSIZE4;
        em.strobe = 4'h0;
        em.data   = 32'h0;
      end
      if (phase == G_WAIT) em.valid = 1'b0;
      ei.data = mresp.data;
      ed.data = mresp.data;
      if (cur_d) begin
        ed.addr_ok = cur_aok;
        ed.data_ok = cur_dok;
      end else begin
        ei.addr_ok = cur_aok;
        ei.data_ok = cur_dok;
      end
    end
    check("mreq_valid", 128'(mreq.valid), 128'(em.valid));
    if (em.valid || reset) check("mreq", 128'(mreq), 128'(em));
    check("iresp", 128'(iresp), 128'(ei));
    check("dresp", 128'(dresp), 128'(ed));
  endtask

  // Record DUT-observed events, cross the clock edge, advance the model.
  task automatic tick();
    if (mreq.valid && mresp.addr_ok) handshakes++;
    if (dresp.data_ok) obs_winners.push_back(1'b1);
    if (iresp.data_ok) obs_winners.push_back(1'b0);
    @(posedge clk);
    done_i = !reset && cur_dok && !cur_d;
    done_d = !reset && cur_dok && cur_d;
    if (reset) begin
      phase = G_NONE;
      fav_d = DF;
    end else if (cur_dok) begin
      phase = G_NONE;
      fav_d = !cur_d;
    end else if (phase == G_WAIT) begin
      phase = G_WAIT;
    end else if (cur_aok) begin
      phase  = G_WAIT;
      hold_d = cur_d;
    end else if (cur_gv) begin
      phase  = G_HELD;
      hold_d = cur_d;
    end else begin
      phase = G_NONE;
    end
    #1;
  endtask

  task automatic cycle();
    step();
    tick();
  endtask

  initial begin
    msize_t rs;
    bit     a;
    reset = 1'b1;
    set_i(1'b0, 32'h0);
    set_d(1'b0, 32'h0, MSIZE1, 4'h0, 32'h0);
    set_m(1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #1;
    cycle();
    cycle();
    reset = 1'b0;

    // Simultaneous requests: dbus first, then ibus with same-cycle completion.
    set_i(1'b1, 32'hbfc0_0000);
    set_d(1'b1, 32'h8000_0010, MSIZE4, 4'hf, 32'h1234_5678);
    set_m(1'b1, 1'b0, 32'h0);
    step();
    check("t1_c0_mreq_addr", 128'(mreq.addr), 128'(32'h8000_0010));
    check("t1_c0_iresp_aok", 128'(iresp.addr_ok), 128'(1'b0));
    tick();
    set_m(1'b0, 1'b0, 32'h0);
    cycle();
    set_m(1'b0, 1'b1, 32'hdead_beef);
    step();
    check("t1_c2_dresp_dok", 128'(dresp.data_ok), 128'(1'b1));
    check("t1_c2_iresp_dok", 128'(iresp.data_ok), 128'(1'b0));
    tick();
    set_d(1'b0, 32'h0, MSIZE1, 4'h0, 32'h0);
    set_m(1'b1, 1'b1, 32'h2408_0001);
    step();
    check("t3_mreq_addr", 128'(mreq.addr), 128'(32'hbfc0_0000));
    check("t3_mreq_size", 128'(mreq.size), 128'(MSIZE4));
    check("t3_mreq_strobe", 128'(mreq.strobe), 128'(4'h0));
    check("t3_iresp", 128'(iresp), 128'({1'b1, 1'b1, 32'h2408_0001}));
    tick();
    // Still idle after the one-cycle transaction: next fetch goes straight out.
    set_i(1'b1, 32'hbfc0_0004);
    set_m(1'b0, 1'b0, 32'h0);
    step();
    check("t3_next_grant", 128'({mreq.valid, mreq.addr}), 128'({1'b1, 32'hbfc0_0004}));
    tick();
    set_i(1'b0, 32'h0);
    cycle();

    // Owner holds valid through a 3-cycle data wait: one downstream transaction.
    handshakes = 0;
    set_d(1'b1, 32'h8000_0020, MSIZE2, 4'h3, 32'h0000_abcd);
    set_m(1'b1, 1'b0, 32'h0);
    cycle();
    set_m(1'b0, 1'b0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      step();
      check("t2_wait_mreq_valid", 128'(mreq.valid), 128'(1'b0));
      tick();
    end
    set_m(1'b0, 1'b1, 32'h5555_aaaa);
    step();
    check("t2_dresp_dok", 128'(dresp.data_ok), 128'(1'b1));
    tick();
    set_d(1'b0, 32'h0, MSIZE1, 4'h0, 32'h0);
    set_m(1'b0, 1'b0, 32'h0);
    cycle();
    check("t2_handshakes", 128'(handshakes), 128'(1));

    // Round robin from reset, both sides always asking, 2-cycle transactions.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    obs_winners.delete();
    set_i(1'b1, 32'h1000_0000);
    set_d(1'b1, 32'h2000_0000, MSIZE4, 4'hf, 32'h0bad_cafe);
    for (int n = 0; n < 40 && obs_winners.size() < 8; n++) begin
      predict();
      if (phase == G_WAIT) set_m(1'b0, 1'b1, $urandom);
      else set_m(cur_gv, 1'b0, $urandom);
      cycle();
    end
    check("t4_completions", 128'(obs_winners.size()), 128'(8));
    for (int k = 0; k < 8 && k < obs_winners.size(); k++)
      check($sformatf("t4_winner_%0d", k), 128'(obs_winners[k]), 128'((k % 2) == 0));
    set_i(1'b0, 32'h0);
    set_d(1'b0, 32'h0, MSIZE1, 4'h0, 32'h0);
    set_m(1'b0, 1'b0, 32'h0);
    cycle();
    cycle();

    // Fetch owner withdraws before addr_ok; pending dbus granted next cycle.
    set_i(1'b1, 32'h1fc0_0100);
    cycle();
    set_d(1'b1, 32'h8000_0040, MSIZE1, 4'h1, 32'h0000_0077);
    step();
    check("t5_no_preempt", 128'(mreq.addr), 128'(32'h1fc0_0100));
    tick();
    set_i(1'b0, 32'h0);
    step();
    check("t5_withdraw_valid", 128'(mreq.valid), 128'(1'b0));
    tick();
    set_m(1'b1, 1'b1, 32'h0000_1111);
    step();
    check("t5_dbus_grant", 128'({mreq.valid, mreq.addr, mreq.strobe}),
          128'({1'b1, 32'h8000_0040, 4'h1}));
    tick();
    set_d(1'b0, 32'h0, MSIZE1, 4'h0, 32'h0);
    set_m(1'b0, 1'b0, 32'h0);
    cycle();

    // Reset in the data wait: nothing stale reaches the former owner.
    set_d(1'b1, 32'h8000_0080, MSIZE4, 4'hf, 32'h0000_0001);
    set_m(1'b1, 1'b0, 32'h0);
    cycle();
    set_m(1'b0, 1'b0, 32'h0);
    cycle();
    reset = 1'b1;
    set_m(1'b0, 1'b1, 32'hbad0_0bad);
    step();
    check("t6_reset_dresp", 128'(dresp), 128'(0));
    tick();
    reset = 1'b0;
    set_d(1'b0, 32'h0, MSIZE1, 4'h0, 32'h0);
    set_m(1'b0, 1'b0, 32'h0);
    step();
    check("t6_post_mreq_valid", 128'(mreq.valid), 128'(1'b0));
    check("t6_post_iresp", 128'(iresp), 128'(0));
    check("t6_post_dresp", 128'(dresp), 128'(0));
    tick();

    // Randomized traffic with a protocol-abiding memory.
    for (int n = 0; n < 600; n++) begin
      if (done_i || !ireq.valid)
        set_i($urandom_range(0, 1) == 1, $urandom & 32'hffff_fffc);
      else if (!(phase == G_WAIT && !hold_d) && $urandom_range(0, 15) == 0)
        set_i(1'b0, ireq.addr);
      if (done_d || !dreq.valid) begin
        case ($urandom_range(0, 2))
          0:       rs = MSIZE1;
          1:       rs = MSIZE2;
          default: rs = MSIZE4;
        endcase
        set_d($urandom_range(0, 1) == 1, $urandom, rs, 4'($urandom_range(0, 15)), $urandom);
      end else if (!(phase == G_WAIT && hold_d) && $urandom_range(0, 15) == 0) begin
        dreq.valid = 1'b0;
      end
      predict();
      if (phase == G_WAIT) begin
        set_m(1'b0, $urandom_range(0, 2) == 0, $urandom);
      end else if (cur_gv) begin
        a = ($urandom_range(0, 1) == 1);
        set_m(a, a && ($urandom_range(0, 2) == 0), $urandom);
      end else begin
        set_m(1'b0, 1'b0, $urandom);
      end
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
